// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STREAK_MAX_DEF = 3;

    // Wide enough for the largest legal latency (4)
    localparam int CNT_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/arb_streak_guard.sv
// Counts consecutive data grants taken while fetch was waiting and forces a
// fetch win once the streak reaches STREAK_MAX (legal values 1 and up).
module arb_streak_guard
    import mem_arb_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic dm_gnt,
    input  logic if_gnt,
    input  logic if_req,
    output logic force_if
);

    localparam int               SW   = $clog2(STREAK_MAX + 1);
    localparam logic [SW-1:0]    SMAX = SW'(STREAK_MAX);

    logic [SW-1:0] streak;

    always_ff @(posedge clock) begin
        if (!reset) begin
            streak <= '0;
        end else if (if_gnt || (dm_gnt && !if_req)) begin
            streak <= '0;
        end else if (dm_gnt && (streak != SMAX)) begin
            streak <= streak + 1'b1;
        end
    end

    assign force_if = (streak == SMAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with a
// fixed read latency. Define ARB_STARVE_GUARD_EN to add the fetch starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ip_if_req,
    input  logic [9:0]  ip_if_addr,
    output logic        op_if_gnt,
    output logic        op_if_rvalid,
    output logic [31:0] op_if_rdata,
    input  logic        ip_dm_req,
    input  logic        ip_dm_we,
    input  logic [9:0]  ip_dm_addr,
    input  logic [31:0] ip_dm_wdata,
    output logic        op_dm_gnt,
    output logic        op_dm_rvalid,
    output logic [31:0] op_dm_rdata,
    output logic        op_mem_en,
    output logic        op_mem_we,
    output logic [9:0]  op_mem_addr,
    output logic [31:0] op_mem_wdata,
    input  logic [31:0] ip_mem_rdata,
    output logic        op_busy
);

    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

    state_t           state;
    owner_t           owner;
    logic             owner_we;
    logic [CNT_W-1:0] cnt;

    logic complete;
    logic can_grant;
    logic force_if;
    logic if_win;
    logic dm_win;

`ifdef ARB_STARVE_GUARD_EN
    arb_streak_guard #(
        .STREAK_MAX (STREAK_MAX)
    ) u_streak_guard (
        .clock    (clock),
        .reset    (reset),
        .dm_gnt   (op_dm_gnt),
        .if_gnt   (op_if_gnt),
        .if_req   (ip_if_req),
        .force_if (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Everything is gated by reset so a low reset silences all outputs at once
    assign complete  = reset && (state == ST_BUSY) && (cnt == LAT_CNT);
    assign can_grant = reset && ((state == ST_IDLE) || complete);

    assign if_win    = ip_if_req && (!ip_dm_req || force_if);
    assign dm_win    = ip_dm_req && !(ip_if_req && force_if);
    assign op_if_gnt = can_grant && if_win;
    assign op_dm_gnt = can_grant && dm_win;

    always_comb begin
        op_mem_en    = 1'b0;
        op_mem_we    = 1'b0;
        op_mem_addr  = '0;
        op_mem_wdata = '0;
        if (op_dm_gnt) begin
            op_mem_en    = 1'b1;
            op_mem_we    = ip_dm_we;
            op_mem_addr  = ip_dm_addr;
            op_mem_wdata = ip_dm_wdata;
        end else if (op_if_gnt) begin
            op_mem_en    = 1'b1;
            op_mem_addr  = ip_if_addr;
        end
    end

    // A new grant in the completion cycle restarts the counter without leaving BUSY
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            cnt      <= '0;
        end else if (op_if_gnt || op_dm_gnt) begin
            state    <= ST_BUSY;
            owner    <= op_dm_gnt ? OWN_DM : OWN_IF;
            owner_we <= op_dm_gnt && ip_dm_we;
            cnt      <= CNT_W'(1);
        end else if (complete) begin
            state    <= ST_IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            cnt      <= '0;
        end else if (state == ST_BUSY) begin
            cnt      <= cnt + 1'b1;
        end
    end

    assign op_busy      = reset && (state == ST_BUSY);
    assign op_if_rvalid = complete && (owner == OWN_IF);
    assign op_dm_rvalid = complete && (owner == OWN_DM);
    assign op_if_rdata  = op_if_rvalid ? ip_mem_rdata : '0;
    assign op_dm_rdata  = (op_dm_rvalid && !owner_we) ? ip_mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance driven from a vector
// table plus corner sequences, and a MEM_LAT=1 instance for back-to-back grants.
module tb_mem_port_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [9:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;

    logic        b_dm_req;
    logic [9:0]  b_dm_addr;
    logic [31:0] b_mem_rdata, b_if_rdata, b_dm_rdata, b_mem_wdata;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [9:0]  b_mem_addr;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.MEM_LAT(2), .STREAK_MAX(3)) dut (
        .clock (clock), .reset (reset),
        .ip_if_req (if_req), .ip_if_addr (if_addr),
        .op_if_gnt (if_gnt), .op_if_rvalid (if_rvalid), .op_if_rdata (if_rdata),
        .ip_dm_req (dm_req), .ip_dm_we (dm_we), .ip_dm_addr (dm_addr), .ip_dm_wdata (dm_wdata),
        .op_dm_gnt (dm_gnt), .op_dm_rvalid (dm_rvalid), .op_dm_rdata (dm_rdata),
        .op_mem_en (mem_en), .op_mem_we (mem_we), .op_mem_addr (mem_addr),
        .op_mem_wdata (mem_wdata), .ip_mem_rdata (mem_rdata), .op_busy (busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .STREAK_MAX(3)) dut_lat1 (
        .clock (clock), .reset (reset),
        .ip_if_req (1'b0), .ip_if_addr (10'h000),
        .op_if_gnt (b_if_gnt), .op_if_rvalid (b_if_rvalid), .op_if_rdata (b_if_rdata),
        .ip_dm_req (b_dm_req), .ip_dm_we (1'b0), .ip_dm_addr (b_dm_addr), .ip_dm_wdata (32'h0),
        .op_dm_gnt (b_dm_gnt), .op_dm_rvalid (b_dm_rvalid), .op_dm_rdata (b_dm_rdata),
        .op_mem_en (b_mem_en), .op_mem_we (b_mem_we), .op_mem_addr (b_mem_addr),
        .op_mem_wdata (b_mem_wdata), .ip_mem_rdata (b_mem_rdata), .op_busy (b_busy)
    );

    // Memory model: fixed contents per address plus a single-entry write overlay
    logic        wr_valid = 1'b0;
    logic [9:0]  wr_addr  = '0;
    logic [31:0] wr_data  = '0;
    logic [31:0] a_p1 = '0, a_p2 = '0, b_p1 = '0;

    function automatic logic [31:0] memInit(input logic [9:0] a);
        case (a)
            10'h004: return 32'h8C22_0000;
            10'h010: return 32'h1111_0010;
            10'h020: return 32'h2222_0020;
            default: return 32'h5A00_0000 | {22'h0, a};
        endcase
    endfunction

    function automatic logic [31:0] memRead(input logic [9:0] a);
        return (wr_valid && (a == wr_addr)) ? wr_data : memInit(a);
    endfunction

    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
        a_p1 <= (mem_en && !mem_we) ? memRead(mem_addr) : 32'hEEEE_1234;
        a_p2 <= a_p1;
        b_p1 <= (b_mem_en && !b_mem_we) ? memRead(b_mem_addr) : 32'hEEEE_1234;
    end
    assign mem_rdata   = a_p2;
    assign b_mem_rdata = b_p1;

    typedef struct {
        string       name;
        logic        if_req;
        logic [9:0]  if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [9:0]  dm_addr;
        logic [31:0] dm_wdata;
        logic        exp_if_gnt;
        logic        exp_dm_gnt;
        logic        exp_we;
        logic [9:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 32'(actual), 32'(expected));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One isolated transaction from idle: grant cycle, then follow it to completion
    task automatic applyStimulus(input vec_t v);
        logic g;
        g = v.exp_if_gnt | v.exp_dm_gnt;
        tick();
        if_req = v.if_req; if_addr = v.if_addr;
        dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
        @(negedge clock);
        checkBit($sformatf("%s.if_gnt", v.name), if_gnt, v.exp_if_gnt);
        checkBit($sformatf("%s.dm_gnt", v.name), dm_gnt, v.exp_dm_gnt);
        checkBit($sformatf("%s.mem_en", v.name), mem_en, g);
        checkBit($sformatf("%s.mem_we", v.name), mem_we, v.exp_we);
        checkOutput($sformatf("%s.mem_addr", v.name), 32'(mem_addr), 32'(v.exp_addr));
        if (v.exp_we) checkOutput($sformatf("%s.mem_wdata", v.name), mem_wdata, v.exp_wdata);
        tick();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clock);
        checkBit($sformatf("%s.busy_t1", v.name), busy, g);
        checkBit($sformatf("%s.rvalid_t1", v.name), if_rvalid | dm_rvalid, 1'b0);
        tick();
        @(negedge clock);
        checkBit($sformatf("%s.busy_t2", v.name), busy, g);
        checkBit($sformatf("%s.if_rvalid", v.name), if_rvalid, v.exp_if_gnt);
        checkBit($sformatf("%s.dm_rvalid", v.name), dm_rvalid, v.exp_dm_gnt);
        checkOutput($sformatf("%s.if_rdata", v.name), if_rdata, v.exp_if_gnt ? v.exp_rdata : 32'h0);
        checkOutput($sformatf("%s.dm_rdata", v.name), dm_rdata, v.exp_dm_gnt ? v.exp_rdata : 32'h0);
        tick();
        @(negedge clock);
        checkBit($sformatf("%s.busy_t3", v.name), busy, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkBit({tag, ".if_gnt"}, if_gnt, 1'b0);
        checkBit({tag, ".dm_gnt"}, dm_gnt, 1'b0);
        checkBit({tag, ".if_rvalid"}, if_rvalid, 1'b0);
        checkBit({tag, ".dm_rvalid"}, dm_rvalid, 1'b0);
        checkOutput({tag, ".if_rdata"}, if_rdata, 32'h0);
        checkOutput({tag, ".dm_rdata"}, dm_rdata, 32'h0);
        checkBit({tag, ".mem_en"}, mem_en, 1'b0);
        checkBit({tag, ".mem_we"}, mem_we, 1'b0);
        checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
        checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        checkBit({tag, ".busy"}, busy, 1'b0);
        checkBit({tag, ".b_dm_gnt"}, b_dm_gnt, 1'b0);
        checkBit({tag, ".b_busy"}, b_busy, 1'b0);
    endtask

    logic [1:0]  order [8];
    logic [1:0]  exp_order;
    int          n_grants;
    logic [31:0] exp_b [4];

    initial begin
        reset = 1'b0;
        if_req = 1'b1; if_addr = 10'h004; dm_req = 1'b1; dm_we = 1'b1;
        dm_addr = 10'h008; dm_wdata = 32'h1234_5678;
        b_dm_req = 1'b1; b_dm_addr = 10'h000;

        //             name            ifr if_a    dmr we dm_a    wdata          eif edm ewe e_addr  e_wdata        e_rdata
        vecs[0] = '{"fetch_004",    1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 32'h0,         1'b1, 1'b0, 1'b0, 10'h004, 32'h0,         32'h8C22_0000};
        vecs[1] = '{"dm_rd_020",    1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 32'h0,         1'b0, 1'b1, 1'b0, 10'h020, 32'h0,         32'h2222_0020};
        vecs[2] = '{"dm_wr_040",    1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 10'h040, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{"both_rd_040",  1'b1, 10'h010, 1'b1, 1'b0, 10'h040, 32'h0,         1'b0, 1'b1, 1'b0, 10'h040, 32'h0,         32'hDEAD_BEEF};
        vecs[4] = '{"no_request",   1'b0, 10'h0AA, 1'b0, 1'b1, 10'h0BB, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 10'h000, 32'h0,         32'h0};
        vecs[5] = '{"fetch_we_3fc", 1'b1, 10'h3FC, 1'b0, 1'b1, 10'h100, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 10'h3FC, 32'h0,         32'h5A00_03FC};

        exp_b[0] = 32'h5A00_0000;
        exp_b[1] = 32'h8C22_0000;
        exp_b[2] = 32'h5A00_0008;
        exp_b[3] = 32'h5A00_000C;

        // Reset held low with both ports requesting: everything must stay quiet
        tick(); tick();
        @(negedge clock);
        checkAllZero("reset_state");
        tick();
        reset = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; b_dm_req = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Contention: data wins first, held fetch follows when the access completes
        tick();
        if_req = 1'b1; if_addr = 10'h010; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
        @(negedge clock);
        checkBit("contend.dm_gnt_t0", dm_gnt, 1'b1);
        checkBit("contend.if_gnt_t0", if_gnt, 1'b0);
        tick();
        dm_req = 1'b0;
        @(negedge clock);
        checkBit("contend.if_gnt_t1", if_gnt, 1'b0);
        tick();
        @(negedge clock);
        checkBit("contend.dm_rvalid_t2", dm_rvalid, 1'b1);
        checkOutput("contend.dm_rdata_t2", dm_rdata, 32'h2222_0020);
        checkBit("contend.if_gnt_t2", if_gnt, 1'b1);
        checkOutput("contend.mem_addr_t2", 32'(mem_addr), 32'h010);
        tick();
        if_req = 1'b0;
        @(negedge clock);
        checkBit("contend.if_rvalid_t3", if_rvalid, 1'b0);
        tick();
        @(negedge clock);
        checkBit("contend.if_rvalid_t4", if_rvalid, 1'b1);
        checkOutput("contend.if_rdata_t4", if_rdata, 32'h1111_0010);

        // Sustained contention from a clean reset: record the grant order
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        if_req = 1'b1; if_addr = 10'h100; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h104;
        n_grants = 0;
        for (int cyc = 0; cyc < 40 && n_grants < 8; cyc++) begin
            @(negedge clock);
            checkBit("streak.gnt_exclusive", if_gnt & dm_gnt, 1'b0);
            if (dm_gnt) begin
                order[n_grants] = 2'd2;
                n_grants++;
            end else if (if_gnt) begin
                order[n_grants] = 2'd1;
                n_grants++;
            end
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        checkOutput("streak.grant_count", 32'(n_grants), 32'd8);
        for (int i = 0; i < n_grants; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_order = ((i % 4) == 3) ? 2'd1 : 2'd2;
`else
            exp_order = 2'd2;
`endif
            checkOutput($sformatf("streak.order[%0d]", i), 32'(order[i]), 32'(exp_order));
        end
        tick(); tick(); tick();

        // Reset during an in-flight read abandons it
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
        @(negedge clock);
        checkBit("rst_mid.dm_gnt_t0", dm_gnt, 1'b1);
        tick();
        reset = 1'b0;
        @(negedge clock);
        checkBit("rst_mid.busy_t1", busy, 1'b0);
        checkBit("rst_mid.dm_gnt_t1", dm_gnt, 1'b0);
        checkBit("rst_mid.mem_en_t1", mem_en, 1'b0);
        tick();
        @(negedge clock);
        checkBit("rst_mid.dm_rvalid_t2", dm_rvalid, 1'b0);
        checkOutput("rst_mid.dm_rdata_t2", dm_rdata, 32'h0);
        checkBit("rst_mid.busy_t2", busy, 1'b0);
        checkBit("rst_mid.dm_gnt_t2", dm_gnt, 1'b0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        checkBit("rst_mid.dm_gnt_t3", dm_gnt, 1'b1);
        tick();
        dm_req = 1'b0;
        tick();
        @(negedge clock);
        checkBit("rst_mid.dm_rvalid_t5", dm_rvalid, 1'b1);
        checkOutput("rst_mid.dm_rdata_t5", dm_rdata, 32'h2222_0020);

        // MEM_LAT=1 instance: four reads granted on consecutive cycles
        tick();
        b_dm_req = 1'b1; b_dm_addr = 10'h000;
        @(negedge clock);
        checkBit("lat1.gnt[0]", b_dm_gnt, 1'b1);
        checkBit("lat1.rvalid_before", b_dm_rvalid, 1'b0);
        for (int k = 1; k < 4; k++) begin
            tick();
            b_dm_addr = 10'(k * 4);
            @(negedge clock);
            checkBit($sformatf("lat1.gnt[%0d]", k), b_dm_gnt, 1'b1);
            checkBit($sformatf("lat1.rvalid[%0d]", k - 1), b_dm_rvalid, 1'b1);
            checkOutput($sformatf("lat1.rdata[%0d]", k - 1), b_dm_rdata, exp_b[k - 1]);
        end
        tick();
        b_dm_req = 1'b0;
        @(negedge clock);
        checkBit("lat1.gnt_after", b_dm_gnt, 1'b0);
        checkBit("lat1.rvalid[3]", b_dm_rvalid, 1'b1);
        checkOutput("lat1.rdata[3]", b_dm_rdata, exp_b[3]);
        tick();
        @(negedge clock);
        checkBit("lat1.idle", b_busy | b_dm_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
